axi_bram2axis: RTL and testbench
================================

# axi_bram2axis

Streams a block of BRAM contents out as an AXI4-Stream master, issuing sequential BRAM reads from address 0 and emitting one stream beat per BRAM word, with tlast on the final beat. It is the transmit-side companion to the AXI-Stream-to-BRAM receiver and sits between on-chip result buffers and the AXI DMA/host write path. A small internal FIFO absorbs the fixed BRAM read latency so that downstream backpressure never drops data.

## Interface
- AXI_DATA_WIDTH, 512: stream data width; must equal BRAM_DATA_WIDTH.
- AXI_XFER_SIZE_WIDTH, 32: width of the transfer size in bytes.
- BRAM_ADDR_WIDTH, 32: BRAM word-address width.
- BRAM_DATA_WIDTH, 512: BRAM word width.
- BRAM_DELAY, 2: cycles from o_b2as_rden to valid i_b2as_rddata; ≥1.
- FIFO_DEPTH, 4: output buffer entries; power of two, ≥ BRAM_DELAY+2.

- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_b2as_start  in  1  start pulse; sampled only in IDLE.
- o_b2as_done  out  1  high while IDLE (ready for a new start).
- i_b2as_data_size_bytes  in  AXI_XFER_SIZE_WIDTH  transfer size; sampled on the accepted start.
- o_b2as_rden  out  1  BRAM read enable.
- o_b2as_rdaddr  out  BRAM_ADDR_WIDTH  BRAM word read address.
- i_b2as_rddata  in  BRAM_DATA_WIDTH  BRAM read data, valid BRAM_DELAY cycles after rden.
- m_axis_tvalid  out  1  stream beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  AXI_DATA_WIDTH  beat data.
- m_axis_tlast  out  1  marks the final beat of the transfer.

## Operation
- Depth = size_bytes*8/BRAM_DATA_WIDTH, truncated; computed with BRAM_ADDR_WIDTH+1 bits and latched on start. Partial trailing words are not sent.
- States: IDLE, BUSY.
  - IDLE -> BUSY on i_b2as_start. Read count, sent count, and FIFO are cleared.
  - BUSY -> IDLE when sent count == depth. With depth 0, BUSY lasts exactly one cycle, and no rden or tvalid is produced.
  - i_b2as_start in BUSY is ignored.
- Read issue:
  - o_b2as_rden = BUSY && (rd_cnt < depth) && (outstanding < FIFO_DEPTH), where outstanding = reads issued − beats popped. A pop in the same cycle is not credited.
  - o_b2as_rdaddr = rd_cnt, which increments on each rden and is 0 in IDLE.
- Return path: a BRAM_DELAY-stage valid shift register tags each rden. When the tag emerges, i_b2as_rddata is pushed into the FIFO. The credit rule guarantees the FIFO never overflows.
- Output:
  - m_axis_tvalid = FIFO not empty. m_axis_tdata is the FIFO head.
  - m_axis_tlast = tvalid && (sent count == depth−1).
  - A pop occurs on tvalid && tready, and sent count increments.
  - While tvalid && !tready, tdata and tlast hold stable.
  - tvalid never deasserts without a handshake.
- Reset mid-transfer: return to IDLE immediately. The FIFO and delay pipeline are flushed, and BRAM data still in flight is discarded.

## Timing
- Reset values: o_b2as_done=1, o_b2as_rden=0, o_b2as_rdaddr=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
- Start sampled at edge 0: BUSY from cycle 1, first rden (addr 0) in cycle 1.
- Read-to-output latency: a rden in cycle c gives rddata in cycle c+BRAM_DELAY, pushed at the end of that cycle, so tvalid appears in cycle c+BRAM_DELAY+1. First beat appears in cycle 2+BRAM_DELAY.
- Throughput: with tready held high and default parameters, one beat per cycle with no bubbles.
- o_b2as_done rises the cycle after the tlast handshake.

## Test plan
- size=256 B (depth 4), tready=1: rden in cycles 1–4 with addr 0–3; beats in cycles 4–7, data = BRAM[0..3]; tlast only in cycle 7; done high in cycle 8.
- size=64 B (depth 1): one rden, one beat with tlast=1; done high the cycle after the handshake.
- size=0 or 63 B: no rden and no tvalid; done is low for exactly one cycle.
- depth 16 with random tready (~50%): all 16 words arrive in order with none lost or duplicated; outstanding never exceeds FIFO_DEPTH; tdata is stable during every stall.
- tready=0 for 10 cycles after start with depth 8: rden stops after 4 reads; when tready rises, 8 beats drain in order.
- rst_n pulsed low mid-transfer, then start with depth 2: outputs go to reset values immediately; the new transfer yields exactly 2 beats from addr 0–1 and no stale data.

Source files
------------

// File: rtl/axi_bram2axis.sv
// Streams BRAM words 0..depth-1 out as AXI4-Stream beats, tlast on the final beat.
// Reads are credit-limited so the output FIFO can always absorb returning BRAM data.
//
// state  | meaning
// IDLE   | waiting for start, done high
// BUSY   | issuing reads and draining beats until sent count reaches depth
module axi_bram2axis #(
    parameter int AXI_DATA_WIDTH      = 512,
    parameter int AXI_XFER_SIZE_WIDTH = 32,
    parameter int BRAM_ADDR_WIDTH     = 32,
    parameter int BRAM_DATA_WIDTH     = 512,
    parameter int BRAM_DELAY          = 2,
    parameter int FIFO_DEPTH          = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_b2as_start,
    output logic                           o_b2as_done,
    input  logic [AXI_XFER_SIZE_WIDTH-1:0] i_b2as_data_size_bytes,
    output logic                           o_b2as_rden,
    output logic [BRAM_ADDR_WIDTH-1:0]     o_b2as_rdaddr,
    input  logic [BRAM_DATA_WIDTH-1:0]     i_b2as_rddata,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic [AXI_DATA_WIDTH-1:0]      m_axis_tdata,
    output logic                           m_axis_tlast
);

    localparam int CW = BRAM_ADDR_WIDTH + 1;
    localparam int PW = AXI_XFER_SIZE_WIDTH + 3;
    localparam int WW = (PW > CW) ? PW : CW;
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [CW-1:0]              r_depth;
    logic [CW-1:0]              r_rd_cnt;
    logic [CW-1:0]              r_sent_cnt;
    logic [CW-1:0]              w_depth;
    logic [CW-1:0]              w_outstanding;
    logic [BRAM_DELAY-1:0]      r_tag;
    logic [AW:0]                r_wptr;
    logic [AW:0]                r_rptr;
    logic [BRAM_DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic                       w_start;
    logic                       w_rden;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_empty;

    // Bits divided by word width, truncated: partial trailing words are dropped.
    assign w_depth       = CW'(WW'({i_b2as_data_size_bytes, 3'b000}) / WW'(BRAM_DATA_WIDTH));
    assign w_start       = (r_state == S_IDLE) && i_b2as_start;
    assign w_outstanding = r_rd_cnt - r_sent_cnt;
    assign w_empty       = (r_wptr == r_rptr);
    assign w_push        = r_tag[BRAM_DELAY-1];
    assign w_pop         = !w_empty && m_axis_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Leave BUSY in the same cycle as the final handshake so done rises right after it.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (i_b2as_start) w_state_nxt = S_BUSY;
            S_BUSY: begin
                if ((r_sent_cnt == r_depth) ||
                    (w_pop && ((r_sent_cnt + CW'(1)) == r_depth))) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_b2as_done   = (r_state == S_IDLE);
        w_rden        = 1'b0;
        o_b2as_rdaddr = '0;
        if (r_state == S_BUSY) begin
            w_rden        = (r_rd_cnt < r_depth) && (w_outstanding < CW'(FIFO_DEPTH));
            o_b2as_rdaddr = r_rd_cnt[BRAM_ADDR_WIDTH-1:0];
        end
    end

    assign o_b2as_rden = w_rden;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_depth    <= '0;
            r_rd_cnt   <= '0;
            r_sent_cnt <= '0;
            r_tag      <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_start) begin
                r_depth    <= w_depth;
                r_rd_cnt   <= '0;
                r_sent_cnt <= '0;
                r_tag      <= '0;
                r_wptr     <= '0;
                r_rptr     <= '0;
            end
        end else begin
            r_tag <= (r_tag << 1) | BRAM_DELAY'(w_rden);
            if (w_rden) r_rd_cnt <= r_rd_cnt + CW'(1);
            if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_pop) begin
                r_rptr     <= r_rptr + (AW+1)'(1);
                r_sent_cnt <= r_sent_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= i_b2as_rddata;
    end

    assign m_axis_tvalid = !w_empty;
    assign m_axis_tdata  = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
    assign m_axis_tlast  = !w_empty && (r_sent_cnt == (r_depth - CW'(1)));

endmodule

// File: tb/tb_axi_bram2axis.sv
// Directed bench for axi_bram2axis: BRAM model with fixed read latency,
// expected beats queued at start and checked by a negedge monitor.
module tb_axi_bram2axis;

    localparam int DW = 512;
    localparam int AW = 32;
    localparam int SW = 32;
    localparam int D  = 2;
    localparam int FD = 4;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          done;
    logic [SW-1:0] size = '0;
    logic          rden;
    logic [AW-1:0] rdaddr;
    logic [DW-1:0] rddata;
    logic          tvalid;
    logic          tready = 1'b1;
    logic [DW-1:0] tdata;
    logic          tlast;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int t0 = 0;

    exp_t          sb[$];
    int            rd_cycles[$];
    int            beat_cycles[$];
    logic [AW-1:0] exp_addr = '0;
    int            rd_issued = 0;
    int            popped = 0;
    int            max_out = 0;
    logic [15:0]   cur_seed = '0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    logic [DW-1:0] pipe [D];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axi_bram2axis #(
        .AXI_DATA_WIDTH(DW), .AXI_XFER_SIZE_WIDTH(SW), .BRAM_ADDR_WIDTH(AW),
        .BRAM_DATA_WIDTH(DW), .BRAM_DELAY(D), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_b2as_start(start), .o_b2as_done(done),
        .i_b2as_data_size_bytes(size),
        .o_b2as_rden(rden), .o_b2as_rdaddr(rdaddr), .i_b2as_rddata(rddata),
        .m_axis_tvalid(tvalid), .m_axis_tready(tready),
        .m_axis_tdata(tdata), .m_axis_tlast(tlast)
    );

    function automatic logic [DW-1:0] word(input logic [15:0] s, input logic [31:0] a);
        return {16{s, a[15:0]}};
    endfunction

    always @(posedge clk) begin
        pipe[0] <= rden ? word(cur_seed, rdaddr) : '0;
        for (int i = 1; i < D; i++) pipe[i] <= pipe[i-1];
    end
    assign rddata = pipe[D-1];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   out_now;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", tvalid, 1);
                chk("stall_data", tdata, prev_data);
                chk("stall_last", tlast, prev_last);
            end
            out_now = rd_issued - popped;
            if (rden) begin
                chk("rdaddr", rdaddr, exp_addr);
                exp_addr++;
                rd_cycles.push_back(cyc - t0);
                if (out_now + 1 > max_out) max_out = out_now + 1;
                rd_issued++;
            end
            if (tvalid && tready) begin
                beat_cycles.push_back(cyc - t0);
                popped++;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_beat: got %0h expected no beat", tdata);
                end else begin
                    e = sb.pop_front();
                    chk("tdata", tdata, e.d);
                    chk("tlast", tlast, e.l);
                end
            end
            if (!tvalid) chk("tlast_without_valid", tlast, 0);
            prev_stall = tvalid && !tready;
            prev_data  = tdata;
            prev_last  = tlast;
        end
    end

    // Leaves the caller in cycle 1 of the transfer (start sampled at the preceding edge).
    task automatic run(input int bytes, input logic [15:0] seed);
        exp_t e;
        int   depth;
        depth = bytes * 8 / DW;
        @(posedge clk); #1;
        size = bytes;
        start = 1'b1;
        cur_seed = seed;
        sb.delete();
        rd_cycles.delete();
        beat_cycles.delete();
        exp_addr = '0;
        rd_issued = 0;
        popped = 0;
        max_out = 0;
        for (int i = 0; i < depth; i++) begin
            e.d = word(seed, i);
            e.l = (i == depth - 1);
            sb.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0;
        t0 = cyc - 1;
    endtask

    task automatic wait_done(input bit rnd, output int dcyc);
        dcyc = -1;
        for (int k = 0; k < 500; k++) begin
            if (done) begin
                dcyc = cyc - t0;
                return;
            end
            @(posedge clk); #1;
            if (rnd) tready = 1'($urandom_range(0, 1));
        end
        n_checks++;
        n_errors++;
        $display("FAIL done_timeout: got done=0 expected done=1 within 500 cycles");
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_rden"}, rden, 0);
        chk({tag, "_rdaddr"}, rdaddr, 0);
        chk({tag, "_tvalid"}, tvalid, 0);
        chk({tag, "_tlast"}, tlast, 0);
        chk({tag, "_tdata"}, tdata, 0);
    endtask

    initial begin
        int dc;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // depth 4, tready high: exact cycle placement of reads, beats and done
        tready = 1'b1;
        run(256, 16'h1111);
        wait_done(0, dc);
        chk("t1_done_cycle", dc, 8);
        chk("t1_rd_count", rd_cycles.size(), 4);
        chk("t1_beat_count", beat_cycles.size(), 4);
        for (int i = 0; i < 4 && i < rd_cycles.size(); i++) chk("t1_rd_cycle", rd_cycles[i], i + 1);
        for (int i = 0; i < 4 && i < beat_cycles.size(); i++) chk("t1_beat_cycle", beat_cycles[i], i + 4);
        chk("t1_sb_empty", sb.size(), 0);

        // depth 1
        run(64, 16'h2222);
        wait_done(0, dc);
        chk("t2_done_cycle", dc, 5);
        chk("t2_rd_count", rd_issued, 1);
        chk("t2_beat_count", popped, 1);
        chk("t2_sb_empty", sb.size(), 0);

        // depth 0 from both 0 B and a partial word
        run(0, 16'h3333);
        wait_done(0, dc);
        chk("t3a_done_cycle", dc, 2);
        chk("t3a_rd_count", rd_issued, 0);
        chk("t3a_beat_count", popped, 0);
        run(63, 16'h3334);
        wait_done(0, dc);
        chk("t3b_done_cycle", dc, 2);
        chk("t3b_rd_count", rd_issued, 0);
        chk("t3b_beat_count", popped, 0);

        // depth 16, random backpressure
        run(1024, 16'h4444);
        wait_done(1, dc);
        tready = 1'b1;
        chk("t4_beat_count", popped, 16);
        chk("t4_rd_count", rd_issued, 16);
        chk("t4_sb_empty", sb.size(), 0);
        chk("t4_max_outstanding_ok", (max_out <= FD), 1);

        // depth 8 with tready low for 10 cycles: reads stall at the credit limit
        tready = 1'b0;
        run(512, 16'h5555);
        repeat (10) @(posedge clk);
        #1;
        chk("t5_rd_stalled", rd_issued, 4);
        chk("t5_no_beats", popped, 0);
        tready = 1'b1;
        wait_done(0, dc);
        chk("t5_beat_count", popped, 8);
        chk("t5_sb_empty", sb.size(), 0);

        // reset mid-transfer, then a clean depth-2 transfer
        run(512, 16'h6666);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(128, 16'h7777);
        wait_done(0, dc);
        chk("t6_done_cycle", dc, 6);
        chk("t6_rd_count", rd_issued, 2);
        chk("t6_beat_count", popped, 2);
        chk("t6_sb_empty", sb.size(), 0);
        repeat (8) @(posedge clk);
        #1;
        chk("t6_no_stale_beats", popped, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
